pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_gen.sv | 124 ++++++++++++
 tb/tb_pwm_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - single-channel PWM generator with channel-filtered, boundary-safe config updates
// Config captures go to a pending set; enables apply at period wraps, disables apply at once.
module pwm_gen #(
  parameter int CHANNEL_ID = 0,
  parameter int CNT_W      = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_config_vld,
  input  logic [7:0]       pwm_config_channel,
  input  logic             pwm_en,
  input  logic [CNT_W-1:0] pwm_period,
  input  logic [CNT_W-1:0] pwm_hlevel,
  output logic             pwm,
  output logic             pwm_period_end,
  output logic             cfg_applied
);

  localparam logic       ST_IDLE = 1'b0;
  localparam logic       ST_RUN  = 1'b1;
  localparam logic [7:0] MY_CH   = 8'(CHANNEL_ID);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] act_period, act_period_n;
  logic [CNT_W-1:0] act_hlevel, act_hlevel_n;

  logic             pend;
  logic             pend_en;
  logic [CNT_W-1:0] pend_period;
  logic [CNT_W-1:0] pend_hlevel;

  logic             capture;
  logic             pend_ok;
  logic             at_wrap;
  logic             consume;
  logic             pwm_n;
  logic             end_n;

  assign capture = pwm_config_vld && (pwm_config_channel == MY_CH);
  assign pend_ok = pend_en && (pend_period != '0);
  assign at_wrap = (state == ST_RUN) && (cnt == act_period - ONE);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    act_period_n = act_period;
    act_hlevel_n = act_hlevel;
    consume      = 1'b0;
    // pwm lags the counter by one cycle, so it reflects the count being left
    pwm_n        = (state == ST_RUN) && (cnt < act_hlevel);
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        pwm_n = 1'b0;
        if (pend) begin
          consume = 1'b1;
          if (pend_ok) begin
            state_n      = ST_RUN;
            act_period_n = pend_period;
            act_hlevel_n = pend_hlevel;
          end
        end
      end
      default: begin
        if (pend && !pend_ok) begin
          consume = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
          pwm_n   = 1'b0;
        end else if (at_wrap) begin
          cnt_n = '0;
          if (pend) begin
            consume      = 1'b1;
            act_period_n = pend_period;
            act_hlevel_n = pend_hlevel;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
    endcase
    end_n = (state_n == ST_RUN) && (cnt_n == act_period_n - ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      act_period     <= '0;
      act_hlevel     <= '0;
      pwm            <= 1'b0;
      pwm_period_end <= 1'b0;
      cfg_applied    <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      act_period     <= act_period_n;
      act_hlevel     <= act_hlevel_n;
      pwm            <= pwm_n;
      pwm_period_end <= end_n;
      cfg_applied    <= consume;
    end
  end

  // A capture on the consuming edge wins, so it stays pending for the next opportunity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      pend_en     <= 1'b0;
      pend_period <= '0;
      pend_hlevel <= '0;
    end else if (capture) begin
      pend        <= 1'b1;
      pend_en     <= pwm_en;
      pend_period <= pwm_period;
      pend_hlevel <= pwm_hlevel;
    end else if (consume) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - scoreboard bench for pwm_gen with a cycle-level reference model
module tb_pwm_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_config_vld = 1'b0;
  logic [7:0]  pwm_config_channel = 8'd0;
  logic        pwm_en = 1'b0;
  logic [15:0] pwm_period = 16'd0;
  logic [15:0] pwm_hlevel = 16'd0;
  logic        pwm, pwm_period_end, cfg_applied;

  int checks = 0;
  int passes = 0;

  pwm_gen #(.CHANNEL_ID(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pwm_config_vld(pwm_config_vld), .pwm_config_channel(pwm_config_channel),
    .pwm_en(pwm_en), .pwm_period(pwm_period), .pwm_hlevel(pwm_hlevel),
    .pwm(pwm), .pwm_period_end(pwm_period_end), .cfg_applied(cfg_applied)
  );

  always #5 clk = ~clk;

  // reference model state: running flag, position in period, active and pending configs
  bit          m_run;
  int unsigned m_cnt, m_per, m_hl;
  bit          p_vld, p_en;
  int unsigned p_per, p_hl;
  logic [2:0]  expq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_cnt = 0; m_per = 0; m_hl = 0;
      p_vld = 0; p_en = 0; p_per = 0; p_hl = 0;
      expq.delete();
    end else begin
      bit e_pwm, e_end, e_app, ok, wrap;
      e_pwm = m_run && (m_cnt < m_hl);
      e_app = 0;
      wrap  = m_run && (m_cnt == m_per - 1);
      ok    = p_en && (p_per != 0);
      if (!m_run) begin
        if (p_vld) begin
          e_app = 1; p_vld = 0;
          if (ok) begin m_run = 1; m_cnt = 0; m_per = p_per; m_hl = p_hl; end
        end
      end else if (p_vld && !ok) begin
        e_app = 1; p_vld = 0; m_run = 0; m_cnt = 0; e_pwm = 0;
      end else if (wrap) begin
        m_cnt = 0;
        if (p_vld) begin e_app = 1; p_vld = 0; m_per = p_per; m_hl = p_hl; end
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (pwm_config_vld && pwm_config_channel == 8'd3) begin
        p_vld = 1; p_en = pwm_en; p_per = pwm_period; p_hl = pwm_hlevel;
      end
      e_end = m_run && (m_cnt == m_per - 1);
      expq.push_back({e_pwm, e_end, e_app});
    end
  end

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [2:0] e;
      e = expq.pop_front();
      checks++;
      if ({pwm, pwm_period_end, cfg_applied} === e) passes++;
      else $display("FAIL cycle_outputs t=%0t {pwm,end,applied} got=%b want=%b", $time,
                    {pwm, pwm_period_end, cfg_applied}, e);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s got=%0d want=%0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] ch, input logic en, input int per, input int hl);
    pwm_config_vld = 1'b1; pwm_config_channel = ch; pwm_en = en;
    pwm_period = 16'(per); pwm_hlevel = 16'(hl);
    @(posedge clk); #1;
    pwm_config_vld = 1'b0;
  endtask

  task automatic measure(input int n, output int hi, output int ends, output int apps);
    hi = 0; ends = 0; apps = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm); ends += int'(pwm_period_end); apps += int'(cfg_applied);
    end
  endtask

  task automatic wait_end();
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (pwm_period_end) found = 1;
    end
    chk("wait_period_end_timeout", int'(found), 1);
  endtask

  initial begin
    int hi, ends, apps;
    rst_n = 1'b0;
    tick(3);
    chk("reset_outputs", int'({pwm, pwm_period_end, cfg_applied}), 0);
    rst_n = 1'b1;
    tick(2);

    send(8'd5, 1'b1, 10, 4);
    measure(15, hi, ends, apps);
    chk("filter_pwm_high", hi, 0);
    chk("filter_applied", apps, 0);

    send(8'd3, 1'b1, 10, 4);
    measure(30, hi, ends, apps);
    chk("start_pwm_high", hi, 12);
    chk("start_period_ends", ends, 2);
    chk("start_applied", apps, 1);

    wait_end();
    tick(3);
    send(8'd3, 1'b1, 6, 3);
    measure(12, hi, ends, apps);
    chk("boundary_pwm_high", hi, 5);
    chk("boundary_period_ends", ends, 1);
    chk("boundary_applied", apps, 1);

    wait_end();
    tick(2);
    chk("disable_pwm_before", int'(pwm), 1);
    send(8'd3, 1'b0, 10, 4);
    tick(1);
    measure(20, hi, ends, apps);
    chk("disable_pwm_high", hi, 0);
    chk("disable_period_ends", ends, 0);
    chk("disable_applied", apps, 1);

    send(8'd3, 1'b1, 10, 0);
    tick(1);
    measure(30, hi, ends, apps);
    chk("hlevel0_pwm_high", hi, 0);
    chk("hlevel0_period_ends", ends, 3);
    chk("hlevel0_applied", apps, 1);

    send(8'd3, 1'b0, 0, 0);
    tick(3);
    send(8'd3, 1'b1, 10, 12);
    tick(2);
    measure(20, hi, ends, apps);
    chk("hlevel_over_pwm_high", hi, 20);
    chk("hlevel_over_period_ends", ends, 2);

    send(8'd3, 1'b1, 0, 5);
    tick(1);
    measure(20, hi, ends, apps);
    chk("period0_run_pwm_high", hi, 0);
    chk("period0_run_applied", apps, 1);
    send(8'd3, 1'b1, 0, 5);
    measure(20, hi, ends, apps);
    chk("period0_idle_ends", ends, 0);
    chk("period0_idle_applied", apps, 1);

    send(8'd3, 1'b1, 10, 4);
    wait_end();
    send(8'd3, 1'b1, 6, 3);
    measure(5, hi, ends, apps);
    chk("wrap_capture_not_early", apps, 0);
    measure(10, hi, ends, apps);
    chk("wrap_capture_next_wrap", apps, 1);

    for (int i = 0; i < 120; i++) begin
      logic [7:0] ch;
      ch = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd3;
      send(ch, ($urandom_range(0, 5) != 0), $urandom_range(0, 7), $urandom_range(0, 9));
      tick($urandom_range(0, 12));
    end

    send(8'd3, 1'b0, 0, 0);
    tick(2);
    send(8'd3, 1'b1, 10, 9);
    wait_end();
    tick(2);
    send(8'd3, 1'b1, 8, 4);
    chk("reset_pwm_high_before", int'(pwm), 1);
    #1 rst_n = 1'b0;
    #1 chk("reset_async_outputs", int'({pwm, pwm_period_end, cfg_applied}), 0);
    tick(3);
    rst_n = 1'b1;
    measure(20, hi, ends, apps);
    chk("post_reset_quiet", hi + ends + apps, 0);

    tick(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
